// File: rtl/store_and_release.sv
// store_and_release: per-lane tuple FIFO with a lockstep release port.
// Tuples arrive on a valid/ready stream, wait in a DEPTH-entry FIFO, and leave one
// per accepted release strobe through a single registered output slot.
// Optional feature macro: SAR_SEQCHECK_EN adds a release counter that is compared
// against the control index on next_i, with a sticky seq_error_o flag.
module store_and_release #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_last_i,
    output logic                  is_stored_o,
    input  logic                  release_data_i,
    input  logic [31:0]           next_i,
    output logic                  local_last_processed_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
`ifdef SAR_SEQCHECK_EN
    ,
    output logic                  seq_error_o
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  last_seen_q, last_seen_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  llp_q, llp_d;

    logic full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Gate with reset so upstream sees not-ready while the lane is held in reset.
    assign in_ready_o  = resetn_i & ~full & ~last_seen_q;
    // Head is offered only when the output slot is free or being drained this cycle.
    assign is_stored_o = ~empty & (~out_valid_q | out_ready_i);

    assign push = in_valid_i & in_ready_o;
    assign pop  = release_data_i & is_stored_o;

    assign out_valid_o            = out_valid_q;
    assign out_data_o             = out_data_q;
    assign local_last_processed_o = llp_q;

    // Next-state for pointers, occupancy, output slot and completion flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_seen_d = last_seen_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        llp_d       = llp_q | (last_seen_q & empty & ~out_valid_q);

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (in_last_i) begin
                last_seen_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A release refills the slot even when it is handed off in the same cycle.
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_seen_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            llp_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_seen_q <= last_seen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            llp_q       <= llp_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

`ifdef SAR_SEQCHECK_EN
    logic [31:0] rel_cnt_q, rel_cnt_d;
    logic        seq_error_q, seq_error_d;

    assign seq_error_o = seq_error_q;

    // Release counter and sticky mismatch against the control index.
    always_comb begin
        rel_cnt_d   = rel_cnt_q;
        seq_error_d = seq_error_q;
        if (pop) begin
            rel_cnt_d = rel_cnt_q + 32'd1;
            if (next_i != rel_cnt_q) begin
                seq_error_d = 1'b1;
            end
        end
    end

    // Sequence-check state registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rel_cnt_q   <= '0;
            seq_error_q <= 1'b0;
        end else begin
            rel_cnt_q   <= rel_cnt_d;
            seq_error_q <= seq_error_d;
        end
    end
`else
    // Index input has no consumer without the sequence check.
    logic unused_next;
    assign unused_next = ^next_i;
`endif

endmodule

// File: tb/tb_store_and_release.sv
// Bench for store_and_release: queue-based reference model plus a scoreboard monitor.
module tb_store_and_release;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          is_stored;
    logic          release_data = 1'b0;
    logic [31:0]   next = '0;
    logic          llp;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
`ifdef SAR_SEQCHECK_EN
    logic          seq_error;
`endif

    store_and_release #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i                  (clk),
        .resetn_i               (resetn),
        .in_valid_i             (in_valid),
        .in_ready_o             (in_ready),
        .in_data_i              (in_data),
        .in_last_i              (in_last),
        .is_stored_o            (is_stored),
        .release_data_i         (release_data),
        .next_i                 (next),
        .local_last_processed_o (llp),
        .out_valid_o            (out_valid),
        .out_ready_i            (out_ready),
        .out_data_o             (out_data)
`ifdef SAR_SEQCHECK_EN
        ,
        .seq_error_o            (seq_error)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stored tuples, the output slot and lane status.
    logic [DW-1:0] m_fifo[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ov, m_last, m_llp;
    logic [31:0]   m_rel;
    bit            m_seq;

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_ov = 0; m_last = 0; m_llp = 0; m_rel = '0; m_seq = 0;
    endtask

    // Model step: compare status outputs, then advance to the next clock edge.
    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_is_stored", 64'(is_stored), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", out_data, 64'd0);
            check("rst_llp", 64'(llp), 64'd0);
            model_reset();
        end else begin
            bit exp_ir, exp_is, acc, rel, nllp;
            exp_ir = (m_fifo.size() < DEPTH) && !m_last;
            exp_is = (m_fifo.size() != 0) && (!m_ov || out_ready);
            check("in_ready", 64'(in_ready), 64'(exp_ir));
            check("is_stored", 64'(is_stored), 64'(exp_is));
            check("out_valid", 64'(out_valid), 64'(m_ov));
            check("llp", 64'(llp), 64'(m_llp));
`ifdef SAR_SEQCHECK_EN
            check("seq_error", 64'(seq_error), 64'(m_seq));
`endif
            acc  = in_valid && exp_ir;
            rel  = release_data && exp_is;
            nllp = m_llp || (m_last && m_fifo.size() == 0 && !m_ov);
            if (rel) begin
                void'(m_fifo.pop_front());
                m_ov = 1;
                if (next != m_rel) m_seq = 1;
                m_rel = m_rel + 32'd1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (acc) begin
                m_fifo.push_back(in_data);
                exp_q.push_back(in_data);
                if (in_last) m_last = 1;
            end
            m_llp = nllp;
        end
    end

    // Scoreboard monitor: every downstream handshake must carry the oldest accepted tuple.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_extra", out_data, 64'hdead_0000_dead_0000);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // Apply one cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit last, input bit rel,
                        input bit ordy);
        in_valid = v; in_data = d; in_last = last; release_data = rel; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 1);
    endtask

    task automatic do_reset();
        resetn = 0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", out_data, 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd0);
        check("async_llp", 64'(llp), 64'd0);
        in_valid = 0; release_data = 0; next = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Three tuples in, nothing released.
        step(1, 64'hA, 0, 0, 1);
        step(1, 64'hB, 0, 0, 1);
        step(1, 64'hC, 0, 0, 1);
        idle(2);
        // Release all three back to back, then one more that must be ignored.
        step(0, '0, 0, 1, 1);
        step(0, '0, 0, 1, 1);
        step(0, '0, 0, 1, 1);
        step(0, '0, 0, 1, 1);
        idle(2);

        // Fill to DEPTH, then push and release together: push refused.
        for (int i = 0; i < DEPTH; i++) step(1, 64'h100 + 64'(i), 0, 0, 1);
        step(1, 64'hBAD, 0, 1, 1);
        step(0, '0, 0, 0, 1);
        // Stall downstream: release must be ignored while the slot is held.
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 4; i++) step(0, '0, 0, 1, 1);
        idle(2);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            next = ($urandom_range(0, 7) != 0) ? m_rel : 32'($urandom);
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end
        next = '0;
        for (int i = 0; i < DEPTH + 4; i++) step(0, '0, 0, 1, 1);
        idle(2);
        check("rand_drain_empty", 64'(exp_q.size()), 64'd0);

        // Final tuple: no further input accepted, completion flag after the drain.
        do_reset();
        step(1, 64'hF00D, 1, 0, 1);
        step(1, 64'hBEEF, 0, 0, 1);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        idle(4);
        check("last_drain_empty", 64'(exp_q.size()), 64'd0);
        check("last_llp_final", 64'(llp), 64'd1);
        check("last_in_ready_final", 64'(in_ready), 64'd0);

`ifdef SAR_SEQCHECK_EN
        // Release indices 0,1,3: third release is out of sequence.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 64'h200 + 64'(i), 0, 0, 1);
        next = 32'd0; step(0, '0, 0, 1, 1);
        next = 32'd1; step(0, '0, 0, 1, 1);
        next = 32'd3; step(0, '0, 0, 1, 1);
        next = 32'd0;
        check("seq_error_set", 64'(seq_error), 64'd1);
        idle(3);
        check("seq_error_sticky", 64'(seq_error), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
